// File: rtl/sub_result_bcd_converter.sv
// Signed {borrow,diff} to sign + 3-digit BCD converter.
// One double-dabble step per cycle; results are held until the next DONE.
module sub_result_bcd_converter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] diff,
  input  logic             borrow,
  output logic             busy,
  output logic             done,
  output logic             sign,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd0,
  output logic             blank2,
  output logic             blank1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic        sign_r;
  logic [8:0]  mag;
  logic [11:0] acc;
  logic [3:0]  count;

  logic signed [WIDTH:0] raw;
  logic signed [8:0]     v_s;
  logic [8:0]            v;
  logic [8:0]            v_neg;
  logic [8:0]            mag_in;
  logic [11:0]           acc_adj;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // borrow is the sign bit, so it also fills any bits above diff
  assign raw    = {borrow, diff};
  assign v_s    = 9'(raw);
  assign v      = v_s;
  assign v_neg  = ~v + 9'd1;
  assign mag_in = borrow ? v_neg : v;

  assign acc_adj = {add3(acc[11:8]),
                    add3(acc[7:4]),
                    add3(acc[3:0])};

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sign_r <= 1'b0;
      mag    <= '0;
      acc    <= '0;
      count  <= '0;
      done   <= 1'b0;
      sign   <= 1'b0;
      bcd2   <= '0;
      bcd1   <= '0;
      bcd0   <= '0;
      blank2 <= 1'b1;
      blank1 <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign_r <= borrow;
            mag    <= mag_in;
            acc    <= '0;
            count  <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= {acc_adj[10:0], mag[8]};
          mag   <= {mag[7:0], 1'b0};
          count <= count + 4'd1;
          if (count == 4'd8) begin
            state <= DONE;
          end
        end
        DONE: begin
          sign   <= sign_r;
          bcd2   <= acc[11:8];
          bcd1   <= acc[7:4];
          bcd0   <= acc[3:0];
          blank2 <= (acc[11:8] == 4'd0);
          blank1 <= (acc[11:4] == 8'd0);
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_result_bcd_converter.sv
// Random and directed checks of sub_result_bcd_converter
// against an arithmetic decimal reference.
module tb_sub_result_bcd_converter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] diff;
  logic       borrow;
  logic       busy;
  logic       done;
  logic       sign;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       blank2;
  logic       blank1;

  int n_cmp = 0;
  int n_bad = 0;

  sub_result_bcd_converter #(.WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .diff   (diff),
    .borrow (borrow),
    .busy   (busy),
    .done   (done),
    .sign   (sign),
    .bcd2   (bcd2),
    .bcd1   (bcd1),
    .bcd0   (bcd0),
    .blank2 (blank2),
    .blank1 (blank1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [7:0] d,
                                input logic b,
                                output int s, output int h,
                                output int t, output int o);
    int val;
    int m;
    val = b ? int'(d) - 256 : int'(d);
    m   = (val < 0) ? -val : val;
    s   = (val < 0) ? 1 : 0;
    h   = m / 100;
    t   = (m / 10) % 10;
    o   = m % 10;
  endfunction

  task automatic check_out(input string tag,
                           input logic [7:0] d,
                           input logic b);
    int s, h, t, o;
    model(d, b, s, h, t, o);
    chk({tag, ".sign"}, 32'(sign), s);
    chk({tag, ".bcd2"}, 32'(bcd2), h);
    chk({tag, ".bcd1"}, 32'(bcd1), t);
    chk({tag, ".bcd0"}, 32'(bcd0), o);
    chk({tag, ".blank2"}, 32'(blank2), (h == 0) ? 1 : 0);
    chk({tag, ".blank1"}, 32'(blank1),
        (h == 0 && t == 0) ? 1 : 0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".sign"}, 32'(sign), 0);
    chk({tag, ".digits"}, {20'd0, bcd2, bcd1, bcd0}, 0);
    chk({tag, ".blanks"}, {30'd0, blank2, blank1}, 3);
  endtask

  // one conversion; inputs are scrambled after accept
  task automatic conv(input string tag,
                      input logic [7:0] d,
                      input logic b);
    int k;
    @(negedge clk);
    diff = d; borrow = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    diff = 8'($urandom); borrow = 1'($urandom);
    k = 1;
    chk({tag, ".busy"}, 32'(busy), 1);
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".lat"}, k, 11);
    check_out(tag, d, b);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(done), 0);
    chk({tag, ".idle"}, 32'(busy), 0);
  endtask

  initial begin
    int dones;
    int t1;
    int t2;
    logic [7:0] rd;
    logic rb;

    reset = 1'b1; start = 1'b0; diff = '0; borrow = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;

    conv("p42", 8'h2A, 1'b0);
    conv("n42", 8'hD6, 1'b1);
    conv("p255", 8'hFF, 1'b0);
    conv("n255", 8'h01, 1'b1);
    conv("n256", 8'h00, 1'b1);
    conv("zero", 8'h00, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rd = 8'($urandom);
      rb = 1'($urandom);
      conv("rand", rd, rb);
    end

    // extra start while busy, inputs changed mid-run
    @(negedge clk);
    diff = 8'h7B; borrow = 1'b0; start = 1'b1;
    dones = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      start = (k == 3);
      if (k == 3) diff = 8'h84;
      if (done) begin
        dones++;
        check_out("busy_start", 8'h7B, 1'b0);
      end
    end
    chk("busy_start.count", dones, 1);

    // held start: back-to-back conversions 11 cycles apart
    @(negedge clk);
    diff = 8'h64; borrow = 1'b0; start = 1'b1;
    t1 = 0; t2 = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (done && t1 == 0) t1 = k;
      else if (done) t2 = k;
    end
    start = 1'b0;
    chk("held.first", t1, 11);
    chk("held.second", t2, 22);
    check_out("held", 8'h64, 1'b0);
    repeat (15) @(negedge clk);

    conv("pre_reset", 8'h2A, 1'b0);

    // reset during conversion
    @(negedge clk);
    diff = 8'hC8; borrow = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset.done", 32'(done), 0);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("mid_reset.count", dones, 0);
    check_cleared("mid_reset");

    conv("nine", 8'h09, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
